// File: rtl/pipe_stage3_if.sv
// rtl/pipe_stage3_if.sv - upstream result stream and SRAM write port bundle for pipe_stage3
interface pipe_stage3_if #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 9
);
    logic                   valid_i;
    logic [2:0]             stage_i;
    logic [WIDTH-1:0]       operand1_i;
    logic [WIDTH-1:0]       operand2_i;
    logic                   finished_i;
    logic                   stall_o;
    logic                   wr_en_o;
    logic                   wr_ready_i;
    logic [3+IDX_W-1:0]     wr_addr_o;
    logic [2*WIDTH-1:0]     wr_data_o;

    // Environment side: upstream producer plus SRAM ready
    modport master (
        output valid_i, stage_i, operand1_i, operand2_i, finished_i, wr_ready_i,
        input  stall_o, wr_en_o, wr_addr_o, wr_data_o
    );

    // Design side
    modport slave (
        input  valid_i, stage_i, operand1_i, operand2_i, finished_i, wr_ready_i,
        output stall_o, wr_en_o, wr_addr_o, wr_data_o
    );
endinterface

// File: rtl/pipe_stage3.sv
// rtl/pipe_stage3.sv - result FIFO and SRAM writer with per-stage index; optional write counter under PIPE_STAGE3_WRCOUNT_EN
module pipe_stage3 #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int IDX_W = 9
) (
    input  logic          CLK_i,
    input  logic          RST_i,
    pipe_stage3_if.slave  bus,
    output logic          overflow_o,
    output logic          done_o,
    output logic [15:0]   wr_count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;

    logic [2:0]         mem_stage [DEPTH];
    logic [WIDTH-1:0]   mem_op1   [DEPTH];
    logic [WIDTH-1:0]   mem_op2   [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic [IDX_W-1:0]   idx;
    logic [2:0]         last_stage;

    logic [2:0]         head_stage;
    logic [IDX_W-1:0]   head_idx;
    logic               accepting;
    logic               fifo_full;
    logic               wr_en;
    logic               pop;
    logic               push;
    logic               drop;

    // Handshake decode; wr_en depends only on registered state so valid_i never reaches it
    always_comb begin
        head_stage = mem_stage[rd_ptr];
        head_idx   = (head_stage == last_stage) ? idx : '0;
        accepting  = (state == IDLE) || (state == RUN);
        fifo_full  = (count == CNT_W'(DEPTH));
        wr_en      = (count != '0) && ((state == RUN) || (state == FLUSH));
        pop        = wr_en && bus.wr_ready_i;
        push       = bus.valid_i && accepting && (!fifo_full || pop);
        drop       = bus.valid_i && accepting && !push;
    end

    assign bus.wr_en_o   = wr_en;
    assign bus.wr_addr_o = {head_stage, head_idx};
    assign bus.wr_data_o = {mem_op2[rd_ptr], mem_op1[rd_ptr]};
    assign bus.stall_o   = (count >= CNT_W'(DEPTH - 1)) || (state == FLUSH);

    // Control FSM; done_o is registered alongside the state
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state  <= IDLE;
            done_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (push) begin
                        state <= RUN;
                    end else if (bus.finished_i && (count == '0)) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.finished_i) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (count == '0) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    done_o <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read
    always_ff @(posedge CLK_i) begin
        if (push) begin
            mem_stage[wr_ptr] <= bus.stage_i;
            mem_op1[wr_ptr]   <= bus.operand1_i;
            mem_op2[wr_ptr]   <= bus.operand2_i;
        end
    end

    // Per-stage address index: restarts at 0 whenever the stage tag changes
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            idx        <= '0;
            last_stage <= 3'd0;
        end else if (pop) begin
            last_stage <= head_stage;
            idx        <= head_idx + IDX_W'(1);
        end
    end

    // Sticky overflow when an entry is refused while still accepting input
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            overflow_o <= 1'b0;
        end else if (drop) begin
            overflow_o <= 1'b1;
        end
    end

`ifdef PIPE_STAGE3_WRCOUNT_EN
    // Saturating count of completed writes
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            wr_count_o <= 16'd0;
        end else if (pop && (wr_count_o != 16'hFFFF)) begin
            wr_count_o <= wr_count_o + 16'd1;
        end
    end
`else
    assign wr_count_o = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_stage3.sv
// tb/tb_pipe_stage3.sv - scoreboard bench for pipe_stage3
module tb_pipe_stage3;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int IDX_W = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        overflow;
    logic        done;
    logic [15:0] wr_count;

    always #5 clk = ~clk;

    pipe_stage3_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

    pipe_stage3 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .CLK_i      (clk),
        .RST_i      (rst),
        .bus        (bus),
        .overflow_o (overflow),
        .done_o     (done),
        .wr_count_o (wr_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [43:0]      sb [$];
    logic [2:0]       m_last;
    logic [IDX_W-1:0] m_idx;
    logic [11:0]      last_addr;
    logic [43:0]      cap;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_count(input int n);
`ifdef PIPE_STAGE3_WRCOUNT_EN
        return (n > 65535) ? 16'hFFFF : 16'(n);
`else
        return 16'd0 + 16'(n * 0);
`endif
    endfunction

    // Write monitor: every accepted write must match the scoreboard head
    always @(negedge clk) begin
        if (!rst && bus.wr_en_o && bus.wr_ready_i) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_write", 64'(bus.wr_en_o), 64'd0);
            end else begin
                check_eq("write", 64'({bus.wr_addr_o, bus.wr_data_o}), 64'(sb.pop_front()));
                last_addr = bus.wr_addr_o;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] st, input logic [15:0] o1, input logic [15:0] o2, input bit accept);
        logic [IDX_W-1:0] a;
        bus.valid_i    = 1'b1;
        bus.stage_i    = st;
        bus.operand1_i = o1;
        bus.operand2_i = o2;
        if (accept) begin
            a      = (st != m_last) ? '0 : m_idx;
            m_last = st;
            m_idx  = a + IDX_W'(1);
            sb.push_back({st, a, o2, o1});
        end
        tick();
        bus.valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        sb.delete();
        m_last = 3'd0;
        m_idx  = '0;
    endtask

    task automatic wait_drain(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && (sb.size() != 0 || bus.wr_en_o); i++) tick();
        check_eq(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        bus.valid_i    = 1'b0;
        bus.stage_i    = 3'd0;
        bus.operand1_i = '0;
        bus.operand2_i = '0;
        bus.finished_i = 1'b0;
        bus.wr_ready_i = 1'b0;
        last_addr      = '0;
        do_reset();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check_eq("rst_wr_en", 64'(bus.wr_en_o), 64'd0);
        check_eq("rst_stall", 64'(bus.stall_o), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_overflow", 64'(overflow), 64'd0);
        check_eq("rst_wr_count", 64'(wr_count), 64'd0);

        // Three stage-4 writes stream straight through
        bus.wr_ready_i = 1'b1;
        push(3'd4, 16'h1111, 16'hA001, 1'b1);
        push(3'd4, 16'h2222, 16'hA002, 1'b1);
        push(3'd4, 16'h3333, 16'hA003, 1'b1);
        wait_drain("drain_stage4", 20);
        check_eq("stage4_last_addr", 64'(last_addr), 64'h802);
        check_eq("count_after_3", 64'(wr_count), 64'(exp_count(3)));

        // Stage change restarts the index
        push(3'd5, 16'h0505, 16'h5050, 1'b1);
        push(3'd5, 16'h0506, 16'h5060, 1'b1);
        push(3'd6, 16'h0606, 16'h6060, 1'b1);
        wait_drain("drain_stage56", 20);
        check_eq("stage6_addr", 64'(last_addr), 64'hC00);
        check_eq("count_after_6", 64'(wr_count), 64'(exp_count(6)));

        // Back-pressure: fill with ready low, stall, overflow, head stability
        bus.wr_ready_i = 1'b0;
        push(3'd1, 16'hB001, 16'hC001, 1'b1);
        check_eq("bp_wr_en", 64'(bus.wr_en_o), 64'd1);
        check_eq("bp_head", 64'({bus.wr_addr_o, bus.wr_data_o}), 64'({12'h200, 16'hC001, 16'hB001}));
        cap = {bus.wr_addr_o, bus.wr_data_o};
        push(3'd1, 16'hB002, 16'hC002, 1'b1);
        check_eq("stall_after_2", 64'(bus.stall_o), 64'd0);
        push(3'd1, 16'hB003, 16'hC003, 1'b1);
        check_eq("stall_after_3", 64'(bus.stall_o), 64'd1);
        push(3'd1, 16'hB004, 16'hC004, 1'b1);
        check_eq("overflow_before_5", 64'(overflow), 64'd0);
        push(3'd1, 16'hB005, 16'hC005, 1'b0);
        check_eq("overflow_after_5", 64'(overflow), 64'd1);
        check_eq("bp_wr_en_held", 64'(bus.wr_en_o), 64'd1);
        check_eq("bp_head_stable", 64'({bus.wr_addr_o, bus.wr_data_o}), 64'(cap));

        // Reset with entries pending drops them all
        do_reset();
        check_eq("rst_mid_wr_en", 64'(bus.wr_en_o), 64'd0);
        check_eq("rst_mid_done", 64'(done), 64'd0);
        check_eq("rst_mid_overflow", 64'(overflow), 64'd0);
        check_eq("rst_mid_wr_count", 64'(wr_count), 64'd0);
        rst = 1'b0;
        tick();
        check_eq("post_rst_wr_en", 64'(bus.wr_en_o), 64'd0);

        // Long run exercising index wrap from 511 to 0
        bus.wr_ready_i = 1'b1;
        for (int i = 0; i < 514; i++) push(3'd2, 16'(i), ~16'(i), 1'b1);
        wait_drain("drain_wrap", 20);
        check_eq("wrap_last_addr", 64'(last_addr), 64'h401);
        check_eq("count_after_wrap", 64'(wr_count), 64'(exp_count(514)));

        // Finish with two entries queued: flush then done
        bus.wr_ready_i = 1'b0;
        push(3'd3, 16'hD001, 16'hE001, 1'b1);
        push(3'd3, 16'hD002, 16'hE002, 1'b1);
        bus.finished_i = 1'b1;
        tick();
        bus.finished_i = 1'b0;
        check_eq("flush_stall", 64'(bus.stall_o), 64'd1);
        check_eq("flush_done_low", 64'(done), 64'd0);
        check_eq("flush_wr_en", 64'(bus.wr_en_o), 64'd1);
        push(3'd3, 16'hD003, 16'hE003, 1'b0);
        check_eq("flush_push_no_ovf", 64'(overflow), 64'd0);
        bus.wr_ready_i = 1'b1;
        for (int i = 0; i < 20 && !done; i++) tick();
        check_eq("done_set", 64'(done), 64'd1);
        check_eq("flush_sb_empty", 64'(sb.size()), 64'd0);
        check_eq("flush_last_addr", 64'(last_addr), 64'h601);
        for (int i = 0; i < 5; i++) tick();
        push(3'd3, 16'hD004, 16'hE004, 1'b0);
        tick();
        check_eq("done_held", 64'(done), 64'd1);
        check_eq("done_no_ovf", 64'(overflow), 64'd0);
        check_eq("done_wr_en", 64'(bus.wr_en_o), 64'd0);
        check_eq("count_final", 64'(wr_count), 64'(exp_count(516)));

        do_reset();
        rst = 1'b0;
        tick();
        check_eq("final_rst_done", 64'(done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stage3.md
PIPE_STAGE3 -- requirements
Module: pipe_stage3

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter IDX_W, default 9, per-stage address index width.
REQ-004 CLK_i  input  1  the only clock; all state updates on its rising edge.
REQ-005 RST_i  input  1  reset, synchronous and active-high.
REQ-006 valid_i  input  1  upstream result valid this cycle.
REQ-007 stage_i  input  3  upstream stage tag, 0..7.
REQ-008 operand1_i  input  WIDTH  upstream operand1 (sqrt, div_mul or center id).
REQ-009 operand2_i  input  WIDTH  upstream operand2 (dnorm in stage 6).
REQ-010 finished_i  input  1  upstream reports stage 7.
REQ-011 stall_o  output  1  drives upstream stall_i.
REQ-012 wr_en_o  output  1  SRAM write request.
REQ-013 wr_ready_i  input  1  SRAM accepts the write this cycle.
REQ-014 wr_addr_o  output  3+IDX_W  write address {stage, idx}.
REQ-015 wr_data_o  output  2*WIDTH  write data {operand2, operand1}.
REQ-016 overflow_o  output  1  sticky flag, an entry was dropped.
REQ-017 done_o  output  1  all results written after finish.
REQ-018 wr_count_o  output  16  number of completed writes (see Configuration).

Function
REQ-019 SHALL hold a DEPTH-entry FIFO of {stage, operand2, operand1}.
REQ-020 Push SHALL occur when valid_i=1, FSM in IDLE or RUN, and (count<DEPTH or a pop occurs in the same cycle).
REQ-021 valid_i=1 while push is refused in IDLE/RUN SHALL set overflow_o; the entry is discarded.
REQ-022 stall_o SHALL be 1 when registered count >= DEPTH-1, or FSM is FLUSH.
REQ-023 wr_en_o SHALL be 1 when the FIFO is non-empty and FSM is RUN or FLUSH; wr_addr_o/wr_data_o reflect the head entry.
REQ-024 Pop SHALL occur when wr_en_o=1 and wr_ready_i=1; wr_en_o, address and data SHALL stay stable while wr_ready_i=0.
REQ-025 Latency: an entry pushed at edge N SHALL appear on wr_en_o no earlier than the cycle after edge N; no combinational valid_i-to-wr_en_o path.
REQ-026 idx SHALL increment by one per pop, wrapping from 2^IDX_W-1 to 0.
REQ-027 idx used for the head entry SHALL be 0 when the head stage differs from the last popped stage.
REQ-028 FSM states: IDLE, RUN, FLUSH, DONE.
REQ-029 IDLE->RUN on the first push; RUN->FLUSH when finished_i=1; IDLE->DONE when finished_i=1 and FIFO empty.
REQ-030 FLUSH->DONE when the FIFO is empty (including the cycle after the last pop); pushes are ignored in FLUSH and DONE without setting overflow_o.
REQ-031 done_o SHALL be 1 exactly in DONE; DONE SHALL be held until reset.

Reset
REQ-032 RST_i=1 at a clock edge SHALL empty the FIFO and set FSM=IDLE, idx=0, last stage=0, overflow_o=0, wr_count_o=0.
REQ-033 Reset mid-transfer SHALL drop all pending entries; wr_en_o=0 in the cycle after reset.

Configuration
REQ-034 With PIPE_STAGE3_WRCOUNT_EN defined, wr_count_o SHALL increment on each pop, saturating at 16'hFFFF.
REQ-035 Without PIPE_STAGE3_WRCOUNT_EN, wr_count_o SHALL be constant 0 and no counter register is built.

Verification
REQ-036 3 pushes stage=4, wr_ready_i=1 -> three writes, addr 0x800,0x801,0x802, data {op2,op1} in order.
REQ-037 wr_ready_i=0, 4 valid pushes (DEPTH=4) -> stall_o=1 after 3rd, 5th push sets overflow_o=1, wr_en_o stable on first entry.
REQ-038 Stage 5 entries then stage 6 entry -> stage 6 write at addr 0xC00 (idx restarts at 0).
REQ-039 2 entries queued, finished_i=1 -> FLUSH, stall_o=1, both written, then done_o=1 held.
REQ-040 RST_i=1 with 3 entries queued -> wr_en_o=0 next cycle, done_o=0, overflow_o=0, wr_count_o=0.
REQ-041 PIPE_STAGE3_WRCOUNT_EN defined, 5 pops -> wr_count_o=5; undefined -> wr_count_o=0.
